// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// chunks of CHUNK bits; each stage resolves one chunk per clock. Operand bits
// that are still unused travel forward with the operation. Finished sum bits
// accumulate, so the whole result leaves the last stage in one beat.
// A single global stall (advance) freezes every register while the output
// holds an unconsumed result.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  logic advance;
  logic ovf_reg;
  logic zero_reg;

  // The pipe moves only when the output slot is empty or being consumed.
  assign advance  = !g_stage[STAGES-1].valid_reg | out_ready;
  assign in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operand bits still needed when an op reaches this stage, and sum
      // bits already resolved by earlier stages.
      localparam int HI = WIDTH - gi * CHUNK;
      localparam int LO = gi * CHUNK;

      logic              v_in;
      logic              c_in;
      logic [HI-1:0]     a_in;
      logic [HI-1:0]     b_in;
      logic [CHUNK:0]    chunk_add;
      logic [LO+CHUNK-1:0] sum_next;

      logic              valid_reg;
      logic              carry_reg;
      logic [LO+CHUNK-1:0] sum_reg;

      if (gi == 0) begin : g_head
        // Subtraction is a + ~b + 1, so the incoming carry is forced high.
        assign v_in     = in_valid;
        assign c_in     = sub | cin;
        assign a_in     = a;
        assign b_in     = sub ? ~b : b;
        assign sum_next = chunk_add[CHUNK-1:0];
      end else begin : g_tail
        assign v_in     = g_stage[gi-1].valid_reg;
        assign c_in     = g_stage[gi-1].carry_reg;
        assign a_in     = g_stage[gi-1].g_fwd.a_reg;
        assign b_in     = g_stage[gi-1].g_fwd.b_reg;
        assign sum_next = {chunk_add[CHUNK-1:0], g_stage[gi-1].sum_reg};
      end

      // CHUNK+1 bit add; the top bit becomes the next stage's carry.
      assign chunk_add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, c_in};

      // Stage register: the valid bit follows every advance, while data loads
      // only for real ops so bubbles leave the last result in place.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (advance) begin
          valid_reg <= v_in;
          if (v_in) begin
            carry_reg <= chunk_add[CHUNK];
            sum_reg   <= sum_next;
          end
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [HI-CHUNK-1:0] a_reg;
        logic [HI-CHUNK-1:0] b_reg;

        // Forward the not-yet-added upper operand chunks with the op.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (advance && v_in) begin
            a_reg <= a_in[HI-1:CHUNK];
            b_reg <= b_in[HI-1:CHUNK];
          end
        end
      end

      if (gi == STAGES - 1) begin : g_flags
        // Flags resolved alongside the top chunk. The carry into the MSB is
        // recovered as a^b^s at that bit, and ovf is that carry XOR the carry out.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
          end else if (advance && v_in) begin
            ovf_reg  <= a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ chunk_add[CHUNK-1]
                      ^ chunk_add[CHUNK];
            zero_reg <= (sum_next == '0);
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].carry_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed bench for pipelined_carry_adder: three instances
// (16/4, 16/1, 32/8) sharing clock and reset.
module tb_pipelined_carry_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: WIDTH=16, STAGES=4
  logic        iv0, ir0, cin0, sub0, ov0, or0, co0, of0, z0;
  logic [15:0] a0, b0, s0;
  // WIDTH=16, STAGES=1
  logic        iv1, ir1, cin1, sub1, ov1, or1, co1, of1, z1;
  logic [15:0] a1, b1, s1;
  // WIDTH=32, STAGES=8
  logic        iv2, ir2, cin2, sub2, ov2, or2, co2, of2, z2;
  logic [31:0] a2, b2, s2;

  pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(s0),
    .cout(co0), .ovf(of0), .zero(z0));

  pipelined_carry_adder #(.WIDTH(16), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .ovf(of1), .zero(z1));

  pipelined_carry_adder #(.WIDTH(32), .STAGES(8)) u_dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(s2),
    .cout(co2), .ovf(of2), .zero(z2));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output view of whichever instance a transaction targets.
  int          sel;
  logic        m_valid, m_ready, m_cout, m_ovf, m_zero;
  logic [31:0] m_sum;
  always_comb begin
    m_valid = 1'b0; m_ready = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    case (sel)
      0: begin m_valid = ov0; m_ready = ir0; m_sum = {16'h0, s0}; m_cout = co0; m_ovf = of0; m_zero = z0; end
      1: begin m_valid = ov1; m_ready = ir1; m_sum = {16'h0, s1}; m_cout = co1; m_ovf = of1; m_zero = z1; end
      default: begin m_valid = ov2; m_ready = ir2; m_sum = s2; m_cout = co2; m_ovf = of2; m_zero = z2; end
    endcase
  end

  // One isolated op on instance s: checks latency and every result field.
  task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic su, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez,
                        input int elat, input string tag);
    int lat;
    sel = s;
    case (s)
      0: begin a0 = av[15:0]; b0 = bv[15:0]; cin0 = ci; sub0 = su; iv0 = 1'b1; end
      1: begin a1 = av[15:0]; b1 = bv[15:0]; cin1 = ci; sub1 = su; iv1 = 1'b1; end
      default: begin a2 = av; b2 = bv; cin2 = ci; sub2 = su; iv2 = 1'b1; end
    endcase
    #1;
    check({tag, " in_ready"}, 32'(m_ready), 32'd1);
    step();
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " sum"}, m_sum, es);
    check({tag, " cout"}, 32'(m_cout), 32'(ec));
    check({tag, " ovf"}, 32'(m_ovf), 32'(eo));
    check({tag, " zero"}, 32'(m_zero), 32'(ez));
    $display("op %s: a=0x%0h b=0x%0h cin=%0b sub=%0b -> sum=0x%0h cout=%0b ovf=%0b zero=%0b lat=%0d",
             tag, av, bv, ci, su, m_sum, m_cout, m_ovf, m_zero, lat);
    step();
  endtask

  // Back-to-back table: a=b=i*0x1111, cin=i[0]
  logic [15:0] exp_s4 [10] = '{16'h0000, 16'h2223, 16'h4444, 16'h6667, 16'h8888,
                               16'hAAAB, 16'hCCCC, 16'hEEEF, 16'h1110, 16'h3333};
  logic        exp_c4 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic        exp_o4 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int          k;
    int          delivered;
    logic [16:0] q[$];
    logic [16:0] frozen;
    logic [16:0] item;
    bit          have_frozen;

    sel = 0;
    iv0 = 0; iv1 = 0; iv2 = 0;
    a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; or0 = 1;
    a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
    a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; or2 = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(ov0), 32'd0);
    check("reset sum", 32'(s0), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("after reset in_ready", 32'(ir0), 32'd1);

    // Basic adds and subtracts, 16/4
    run_op(0, 32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0, 1'b0, 4, "s4 1+1");
    run_op(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 4, "s4 ffff+0+1");
    run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 4, "s4 7fff+1");
    run_op(0, 32'h0005, 32'h0009, 1'b1, 1'b1, 32'hFFFC, 1'b0, 1'b0, 1'b0, 4, "s4 5-9");
    run_op(0, 32'h0009, 32'h0005, 1'b0, 1'b1, 32'h0004, 1'b1, 1'b0, 1'b0, 4, "s4 9-5");
    run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0, 4, "s4 8000-1");

    // Back-to-back stream with out_ready=1
    sel = 0;
    for (int t = 0; t <= 14; t++) begin
      if (t >= 4 && t < 14) begin
        check("b2b out_valid", 32'(ov0), 32'd1);
        check("b2b sum", 32'(s0), 32'(exp_s4[t-4]));
        check("b2b cout", 32'(co0), 32'(exp_c4[t-4]));
        check("b2b ovf", 32'(of0), 32'(exp_o4[t-4]));
        check("b2b zero", 32'(z0), 32'((t == 4) ? 1 : 0));
        $display("b2b result %0d: sum=0x%0h cout=%0b ovf=%0b", t - 4, s0, co0, of0);
      end else begin
        check("b2b idle out_valid", 32'(ov0), 32'd0);
      end
      check("b2b in_ready", 32'(ir0), 32'd1);
      if (t < 10) begin
        iv0 = 1'b1; a0 = 16'(t * 32'h1111); b0 = 16'(t * 32'h1111); cin0 = t[0]; sub0 = 1'b0;
      end else begin
        iv0 = 1'b0;
      end
      step();
    end

    // Backpressure: out_ready held low for the first 6 cycles
    k = 0; delivered = 0; have_frozen = 0; frozen = '0;
    for (int t = 0; t < 40; t++) begin
      or0 = (t >= 6);
      #1;
      if (ov0 && !or0) begin
        if (have_frozen) begin
          check("bp hold sum", 32'(s0), 32'(frozen[15:0]));
          check("bp hold cout", 32'(co0), 32'(frozen[16]));
        end
        frozen = {co0, s0};
        have_frozen = 1;
      end
      if (ov0 && or0) begin
        if (q.size() == 0) begin
          check("bp spurious result, queue size", 32'(q.size()), 32'd1);
        end else begin
          item = q.pop_front();
          check("bp sum", 32'(s0), 32'(item[15:0]));
          check("bp cout", 32'(co0), 32'(item[16]));
          $display("bp deliver %0d: sum=0x%0h cout=%0b", delivered, s0, co0);
          delivered++;
        end
      end
      if (t == 5) check("bp stalled in_ready", 32'(ir0), 32'd0);
      if (k < 8) begin
        iv0 = 1'b1;
        a0 = 16'(32'h1234 + k * 32'h2101);
        b0 = 16'(32'hF00F + k * 32'h0731);
        cin0 = k[0];
        sub0 = k[1];
        if (ir0) begin
          if (sub0) q.push_back({1'b0, a0} + {1'b0, ~b0} + 17'd1);
          else      q.push_back({1'b0, a0} + {1'b0, b0} + {16'h0, cin0});
          k++;
        end
      end else begin
        iv0 = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check("bp leftover queue", 32'(q.size()), 32'd0);
    check("bp delivered count", 32'(delivered), 32'd8);

    // Reset with a result at the output and 3 ops in flight
    or0 = 1'b0;
    for (int t = 0; t < 5; t++) begin
      iv0 = 1'b1; a0 = 16'(32'h0F00 + t); b0 = 16'h0100; cin0 = 1'b0; sub0 = 1'b0;
      step();
    end
    iv0 = 1'b0;
    check("pre-reset out_valid", 32'(ov0), 32'd1);
    check("pre-reset sum", 32'(s0), 32'h1000);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(ov0), 32'd0);
    check("mid reset sum", 32'(s0), 32'd0);
    check("mid reset cout", 32'(co0), 32'd0);
    check("mid reset ovf", 32'(of0), 32'd0);
    check("mid reset zero", 32'(z0), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    or0 = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      check("post-reset no stale", 32'(ov0), 32'd0);
    end
    run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0, 1'b0, 4, "s4 post-reset");

    // STAGES=1
    run_op(1, 32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0, 1'b0, 1, "s1 1+1");
    run_op(1, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 1, "s1 ffff+0+1");
    run_op(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 1, "s1 7fff+1");

    // WIDTH=32, STAGES=8
    run_op(2, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 8, "w32 1+1");
    run_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 8, "w32 ffffffff+0+1");
    run_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 8, "w32 7fffffff+1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
